// File: rtl/charli_pwm_scan.sv
// Charlieplexed LED scanner with per-LED PWM and a blanked first phase in every slot.
// Optional double buffering of the frame store is enabled by defining CHARLI_DOUBLE_BUFFER_EN.
module charli_pwm_scan #(
    parameter int PINS     = 4,
    parameter int PRESCALE = 8192,
    parameter int PWM_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 led_we,
    input  logic [$clog2(PINS*(PINS-1))-1:0]     led_addr,
    input  logic [PWM_BITS-1:0]                  led_level,
    input  logic                                 frame_swap,
    output logic                                 swap_done,
    output logic [PINS-1:0]                      pin_oe,
    output logic [PINS-1:0]                      pin_out,
    inout  wire  [PINS-1:0]                      charli_pin
);

    localparam int LEDS = PINS * (PINS - 1);
    localparam int AW   = $clog2(LEDS);
    localparam int CW   = $clog2(PRESCALE);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       slot_q, slot_d;
    logic [PINS-1:0]     pin_oe_q, pin_oe_d;
    logic [PINS-1:0]     pin_out_q, pin_out_d;
    logic [PWM_BITS-1:0] front_q [LEDS];

    logic [PWM_BITS-1:0] phase;
    logic [PWM_BITS-1:0] cur_level;
    logic [PINS-1:0]     anode_mask, cathode_mask;
    logic                slot_end, frame_end, lit;

    assign phase     = cnt_q[CW-1 -: PWM_BITS];
    assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
    assign frame_end = slot_end && (slot_q == AW'(LEDS - 1));

    // LED k sits at d = k/PINS + 1, i = k%PINS: anode i, cathode (i+d) mod PINS.
    always_comb begin
        anode_mask   = '0;
        cathode_mask = '0;
        cur_level    = '0;
        for (int k = 0; k < LEDS; k++) begin
            if (slot_q == AW'(k)) begin
                anode_mask   = PINS'(1) << (k % PINS);
                cathode_mask = PINS'(1) << (((k % PINS) + (k / PINS) + 1) % PINS);
                cur_level    = front_q[k];
            end
        end
    end

    always_comb begin
        lit       = (phase != '0) && (phase <= cur_level);
        pin_oe_d  = lit ? (anode_mask | cathode_mask) : '0;
        pin_out_d = lit ? anode_mask : '0;
        cnt_d     = cnt_q + CW'(1);
        slot_d    = slot_q;
        if (slot_end) begin
            slot_d = (slot_q == AW'(LEDS - 1)) ? '0 : slot_q + AW'(1);
        end
    end

`ifdef CHARLI_DOUBLE_BUFFER_EN
    // frame_swap is a level-free request: any high cycle arms the swap, which
    // executes at the frame boundary edge and is acknowledged by a 1-cycle swap_done.
    logic [PWM_BITS-1:0] back_q [LEDS];
    logic                swap_pending_q;
    logic                swap_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            slot_q         <= '0;
            pin_oe_q       <= '0;
            pin_out_q      <= '0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            for (int k = 0; k < LEDS; k++) begin
                front_q[k] <= '0;
                back_q[k]  <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pin_oe_q    <= pin_oe_d;
            pin_out_q   <= pin_out_d;
            swap_done_q <= 1'b0;
            if (frame_end && (swap_pending_q || frame_swap)) begin
                for (int k = 0; k < LEDS; k++) begin
                    front_q[k] <= back_q[k];
                end
                swap_pending_q <= 1'b0;
                swap_done_q    <= 1'b1;
            end else if (frame_swap) begin
                swap_pending_q <= 1'b1;
            end
            // Out-of-range addresses match no entry and are dropped.
            for (int k = 0; k < LEDS; k++) begin
                if (led_we && (led_addr == AW'(k))) begin
                    back_q[k] <= led_level;
                end
            end
        end
    end

    assign swap_done = swap_done_q;
`else
    logic unused_frame_swap;
    assign unused_frame_swap = frame_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            slot_q    <= '0;
            pin_oe_q  <= '0;
            pin_out_q <= '0;
            for (int k = 0; k < LEDS; k++) begin
                front_q[k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            pin_oe_q  <= pin_oe_d;
            pin_out_q <= pin_out_d;
            for (int k = 0; k < LEDS; k++) begin
                if (led_we && (led_addr == AW'(k))) begin
                    front_q[k] <= led_level;
                end
            end
        end
    end

    assign swap_done = 1'b0;
`endif

    assign pin_oe  = pin_oe_q;
    assign pin_out = pin_out_q;

    for (genvar p = 0; p < PINS; p++) begin : g_pin
        assign charli_pin[p] = pin_oe_q[p] ? pin_out_q[p] : 1'bz;
    end

endmodule

// File: tb/tb_charli_pwm_scan.sv
// Directed bench for charli_pwm_scan (PINS=3, PRESCALE=16, PWM_BITS=2, six LEDs).
// Covers both CHARLI_DOUBLE_BUFFER_EN builds.
module tb_charli_pwm_scan;

    localparam int PINS     = 3;
    localparam int PRESCALE = 16;
    localparam int PWM_BITS = 2;
    localparam int LEDS     = 6;
    localparam int FRAME    = LEDS * PRESCALE;

    logic       clk = 1'b0;
    logic       rst;
    logic       led_we;
    logic [2:0] led_addr;
    logic [1:0] led_level;
    logic       frame_swap;
    logic       swap_done;
    logic [2:0] pin_oe;
    logic [2:0] pin_out;
    wire  [2:0] charli_pin;

    charli_pwm_scan #(.PINS(PINS), .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_we     (led_we),
        .led_addr   (led_addr),
        .led_level  (led_level),
        .frame_swap (frame_swap),
        .swap_done  (swap_done),
        .pin_oe     (pin_oe),
        .pin_out    (pin_out),
        .charli_pin (charli_pin)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Anode/cathode pairs for LEDs 0..5, worked out by hand.
    int anode_t [LEDS] = '{0, 1, 2, 0, 1, 2};
    int cath_t  [LEDS] = '{1, 2, 0, 2, 0, 1};

    int on_zero [LEDS] = '{0, 0, 0, 0, 0, 0};
    int on_led4 [LEDS] = '{0, 0, 0, 0, 12, 0};
    int on_pwm  [LEDS] = '{0, 4, 8, 12, 4, 0};
    int on_pwm2 [LEDS] = '{0, 4, 12, 12, 4, 0};
    int on_led1 [LEDS] = '{0, 8, 0, 0, 0, 0};

    int disp [LEDS];
    int bk   [LEDS];
    bit pend;
    bit exp_sd;

    int wr_f[$];
    int wr_a[$];
    int wr_l[$];
    int swap_f = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sched_wr(input int f, input int a, input int l);
        wr_f.push_back(f);
        wr_a.push_back(a);
        wr_l.push_back(l);
    endtask

    task automatic model_reset();
        for (int i = 0; i < LEDS; i++) begin
            disp[i] = 0;
            bk[i]   = 0;
        end
        pend   = 1'b0;
        exp_sd = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        led_we     = 1'b0;
        frame_swap = 1'b0;
        led_addr   = 3'd0;
        led_level  = 2'd0;
        step();
        check_eq("rst_pin_oe", {29'b0, pin_oe}, 32'd0);
        check_eq("rst_pin_out", {29'b0, pin_out}, 32'd0);
        check_eq("rst_charli_pin", {29'b0, charli_pin}, {29'b0, 3'bzzz});
        check_eq("rst_swap_done", {31'b0, swap_done}, 32'd0);
        for (int i = 1; i < n; i++) step();
        model_reset();
        rst = 1'b0;
    endtask

    // Runs edges f = 0..len-1 of a frame, starting on a frame boundary.
    task automatic run_frame(input int len, input int exp_on [LEDS]);
        int       on_cnt [LEDS];
        int       s, c, ph, cur_a, cur_l;
        bit       on, cur_we, cur_sw;
        logic [2:0] e_oe, e_out, e_pin, mask;
        for (int i = 0; i < LEDS; i++) on_cnt[i] = 0;
        for (int f = 0; f < len; f++) begin
            cur_we = 1'b0;
            cur_a  = 0;
            cur_l  = 0;
            if (wr_f.size() != 0 && wr_f[0] == f) begin
                cur_we = 1'b1;
                cur_a  = wr_a.pop_front();
                cur_l  = wr_l.pop_front();
                void'(wr_f.pop_front());
            end
            cur_sw     = (swap_f == f);
            led_we     = cur_we;
            led_addr   = 3'(cur_a);
            led_level  = 2'(cur_l);
            frame_swap = cur_sw;

            s  = f / PRESCALE;
            c  = f % PRESCALE;
            ph = c / (PRESCALE / 4);
            on = (ph != 0) && (ph <= disp[s]);
            mask  = (3'(1) << anode_t[s]) | (3'(1) << cath_t[s]);
            e_oe  = on ? mask : 3'b000;
            e_out = on ? (3'(1) << anode_t[s]) : 3'b000;
            for (int p = 0; p < PINS; p++) e_pin[p] = e_oe[p] ? e_out[p] : 1'bz;

`ifdef CHARLI_DOUBLE_BUFFER_EN
            exp_sd = 1'b0;
            if (f == FRAME - 1 && (pend || cur_sw)) begin
                for (int i = 0; i < LEDS; i++) disp[i] = bk[i];
                pend   = 1'b0;
                exp_sd = 1'b1;
            end else if (cur_sw) begin
                pend = 1'b1;
            end
            if (cur_we && cur_a < LEDS) bk[cur_a] = cur_l;
`else
            exp_sd = 1'b0;
            if (cur_we && cur_a < LEDS) disp[cur_a] = cur_l;
`endif

            step();
            check_eq($sformatf("pin_oe_f%0d", f), {29'b0, pin_oe}, {29'b0, e_oe});
            check_eq($sformatf("pin_out_f%0d", f), {29'b0, pin_out}, {29'b0, e_out});
            check_eq($sformatf("charli_pin_f%0d", f), {29'b0, charli_pin}, {29'b0, e_pin});
            check_eq($sformatf("swap_done_f%0d", f), {31'b0, swap_done}, {31'b0, exp_sd});
            if (pin_oe == mask && pin_out == (3'(1) << anode_t[s])) on_cnt[s]++;
        end
        led_we     = 1'b0;
        frame_swap = 1'b0;
        swap_f     = -1;
        if (len == FRAME) begin
            for (int i = 0; i < LEDS; i++)
                check_eq($sformatf("on_cycles_slot%0d", i), on_cnt[i], exp_on[i]);
        end
    endtask

    initial begin
        led_we     = 1'b0;
        led_addr   = 3'd0;
        led_level  = 2'd0;
        frame_swap = 1'b0;
        model_reset();

        do_reset(3);
        check_eq("post_rst_pin_oe", {29'b0, pin_oe}, 32'd0);
        check_eq("post_rst_pin_out", {29'b0, pin_out}, 32'd0);
        check_eq("post_rst_swap_done", {31'b0, swap_done}, 32'd0);
        run_frame(FRAME, on_zero);

`ifdef CHARLI_DOUBLE_BUFFER_EN
        // Single LED: shows up only after the swap at the boundary.
        sched_wr(2, 4, 3);
        swap_f = 10;
        run_frame(FRAME, on_zero);
        run_frame(FRAME, on_led4);

        // PWM levels 0,1,2,3,1,0.
        for (int k = 0; k < LEDS; k++) sched_wr(k, k, on_pwm[k] / 4);
        swap_f = 6;
        run_frame(FRAME, on_led4);
        run_frame(FRAME, on_pwm);

        // Write and swap request both land on the boundary edge.
        sched_wr(FRAME - 1, 2, 3);
        swap_f = FRAME - 1;
        run_frame(FRAME, on_pwm);
        swap_f = 0;
        run_frame(FRAME, on_pwm);
        run_frame(FRAME, on_pwm2);

        // Out-of-range addresses.
        sched_wr(0, 6, 3);
        sched_wr(1, 7, 3);
        swap_f = 2;
        run_frame(FRAME, on_pwm2);
        run_frame(FRAME, on_pwm2);

        // Reset while slot 3 is lit and a swap is pending.
        swap_f = 3;
        sched_wr(4, 0, 3);
        run_frame(57, on_zero);
        do_reset(3);
        run_frame(FRAME, on_zero);
`else
        // Direct writes reach the display without a swap; swap requests are ignored.
        sched_wr(0, 1, 2);
        swap_f = 0;
        run_frame(FRAME, on_led1);
        run_frame(FRAME, on_led1);

        sched_wr(0, 6, 3);
        run_frame(FRAME, on_led1);

        for (int k = 0; k < LEDS; k++) sched_wr(k, k, on_pwm[k] / 4);
        run_frame(FRAME, on_pwm);
        run_frame(FRAME, on_pwm);

        swap_f = 3;
        run_frame(57, on_zero);
        do_reset(3);
        run_frame(FRAME, on_zero);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
